// File: rtl/threshold_compress_stream.sv
// Streaming threshold quantiser: each input element becomes a ternary trit (5 per byte, base-3)
// or a binary bit, and the elements are packed into OUTPUT_WIDTH-bit output words.
module threshold_compress_stream #(
    parameter int unsigned OUTPUT_WIDTH = 8,
    localparam int unsigned COUNTER_WIDTH = $clog2(OUTPUT_WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     mode_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [31:0]              data_i,
    input  logic [31:0]              thresholds_i,
    input  logic                     flush_i,
    output logic [OUTPUT_WIDTH-1:0]  data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [COUNTER_WIDTH-1:0] counter_o
);

    localparam int unsigned TRITS_PER_WORD = 5 * OUTPUT_WIDTH / 8;
    localparam int unsigned BITS_PER_WORD  = OUTPUT_WIDTH;
    localparam int unsigned BYTES_PER_WORD = OUTPUT_WIDTH / 8;

    if (OUTPUT_WIDTH != 8 && OUTPUT_WIDTH != 16 && OUTPUT_WIDTH != 24 && OUTPUT_WIDTH != 32) begin : g_bad_width
        $error("OUTPUT_WIDTH must be 8, 16, 24 or 32");
    end

    logic [COUNTER_WIDTH-1:0]          cnt_q, last_idx;
    logic [TRITS_PER_WORD-1:0][1:0]    dig_q, dig_d;
    logic [BITS_PER_WORD-1:0]          bits_q, bits_d;
    logic [OUTPUT_WIDTH-1:0]           data_q, word_d;
    logic                              valid_q, mode_q;
    logic                              cur_mode, stall, ready, accept, flush_take, complete;
    logic                              gt, lt;
    logic signed [31:0]                hi_s, lo_s;
    logic [1:0]                        digit;
    int unsigned                       sum, weight;

    always_comb begin
        hi_s     = {{16{thresholds_i[31]}}, thresholds_i[31:16]};
        lo_s     = {{16{thresholds_i[15]}}, thresholds_i[15:0]};
        gt       = $signed(data_i) > hi_s;
        lt       = $signed(data_i) < lo_s;
        digit    = gt ? 2'd2 : (lt ? 2'd0 : 2'd1);

        cur_mode = (cnt_q == '0) ? mode_i : mode_q;
        last_idx = cur_mode ? COUNTER_WIDTH'(BITS_PER_WORD - 1) : COUNTER_WIDTH'(TRITS_PER_WORD - 1);
        stall    = valid_q && !ready_i;
        // Hold off anything that would complete a word while the output register is still occupied.
        ready    = enable_i && rst_ni && !(stall && ((cnt_q == last_idx) || flush_i));
        accept   = valid_i && ready;
        flush_take = enable_i && flush_i && !stall && ((cnt_q != '0) || accept);
        complete   = (accept && (cnt_q == last_idx)) || flush_take;

        dig_d  = dig_q;
        bits_d = bits_q;
        if (accept) begin
            if (cur_mode) begin
                bits_d[cnt_q] = gt;
            end else begin
                dig_d[cnt_q] = digit;
            end
        end

        // Unfilled digits idle at 1 (trit 0), so flush padding falls out of the base-3 sum.
        word_d = '0;
        sum    = 0;
        weight = 1;
        if (cur_mode) begin
            word_d = bits_d;
        end else begin
            for (int unsigned g = 0; g < BYTES_PER_WORD; g++) begin
                sum    = 0;
                weight = 1;
                for (int unsigned i = 0; i < 5; i++) begin
                    sum    = sum + 32'(dig_d[5*g+i]) * weight;
                    weight = weight * 3;
                end
                word_d[8*g +: 8] = 8'(sum);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            dig_q   <= {TRITS_PER_WORD{2'd1}};
            bits_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
        end else if (enable_i) begin
            if (accept && (cnt_q == '0)) begin
                mode_q <= mode_i;
            end
            if (complete) begin
                data_q  <= word_d;
                valid_q <= 1'b1;
                cnt_q   <= '0;
                dig_q   <= {TRITS_PER_WORD{2'd1}};
                bits_q  <= '0;
            end else begin
                if (accept) begin
                    cnt_q  <= cnt_q + COUNTER_WIDTH'(1);
                    dig_q  <= dig_d;
                    bits_q <= bits_d;
                end
                if (valid_q && ready_i) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign ready_o   = ready;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign counter_o = cnt_q;

endmodule
